// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-port register file and its busy scoreboard.
package regfile_pkg;
   localparam int DEF_DATA_WIDTH    = 32;
   localparam int DEF_ADDRESS_WIDTH = 5;
   localparam int DEF_NUM_REGS      = 32;
   localparam int ZERO_ADDR         = 0;

   typedef logic [DEF_DATA_WIDTH-1:0]    reg_data_t;
   typedef logic [DEF_ADDRESS_WIDTH-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set by decode reservations, cleared by writeback or a flush.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
   parameter int NUM_REGS      = DEF_NUM_REGS,
   parameter int NUM_RD        = 2,
   parameter int NUM_WR        = 2,
   parameter int ZERO_REG      = 1
)(
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            flush,
   input  logic                            rsv_en,
   input  logic [ADDRESS_WIDTH-1:0]        rsv_addr,
   input  logic [NUM_WR-1:0]               wr_ok,
   input  logic [NUM_WR*ADDRESS_WIDTH-1:0] wr_addr,
   input  logic [NUM_RD*ADDRESS_WIDTH-1:0] rd_addr,
   input  logic [NUM_RD-1:0]               fwd,
   output logic [NUM_RD-1:0]               rd_busy
);
   localparam int AW = ADDRESS_WIDTH;

   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] rsv_set;
   logic [NUM_REGS-1:0] wr_clr;

   function automatic logic addr_ok(input logic [AW-1:0] a);
      return ({1'b0, a} < (AW+1)'(NUM_REGS)) && !(ZERO_REG != 0 && a == AW'(ZERO_ADDR));
   endfunction

   always_comb begin
      rsv_set = '0;
      wr_clr  = '0;
      if (rsv_en && addr_ok(rsv_addr))
         rsv_set[rsv_addr] = 1'b1;
      // wr_ok is already range/zero qualified by the parent
      for (int p = 0; p < NUM_WR; p++)
         if (wr_ok[p])
            wr_clr[wr_addr[p*AW +: AW]] = 1'b1;
   end

   // A reservation beats a same-cycle write: the reserving instruction is the newer producer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         busy <= '0;
      else if (flush)
         busy <= '0;
      else
         busy <= rsv_set | (busy & ~wr_clr);
   end

   always_comb begin
      rd_busy = '0;
      for (int k = 0; k < NUM_RD; k++)
         if (addr_ok(rd_addr[k*AW +: AW]) && !fwd[k])
            rd_busy[k] = busy[rd_addr[k*AW +: AW]];
   end
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: prioritised writes, combinational reads with optional bypass.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
   parameter int NUM_REGS      = DEF_NUM_REGS,
   parameter int NUM_RD        = 2,
   parameter int NUM_WR        = 2,
   parameter int ZERO_REG      = 1,
   parameter int BYPASS        = 1
)(
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_WR-1:0]               wr_en,
   input  logic [NUM_WR*ADDRESS_WIDTH-1:0] wr_addr,
   input  logic [NUM_WR*DATA_WIDTH-1:0]    wr_data,
   input  logic [NUM_RD*ADDRESS_WIDTH-1:0] rd_addr,
   output logic [NUM_RD*DATA_WIDTH-1:0]    rd_data,
   output logic [NUM_RD-1:0]               rd_busy,
   input  logic                            rsv_en,
   input  logic [ADDRESS_WIDTH-1:0]        rsv_addr,
   input  logic                            flush,
   output logic [NUM_REGS*DATA_WIDTH-1:0]  register_file
);
   localparam int AW = ADDRESS_WIDTH;
   localparam int DW = DATA_WIDTH;

   logic [DW-1:0]     regs [NUM_REGS];
   logic [AW-1:0]     wa   [NUM_WR];
   logic [DW-1:0]     wd   [NUM_WR];
   logic [AW-1:0]     ra   [NUM_RD];
   logic [NUM_WR-1:0] wr_ok;
   logic [NUM_RD-1:0] fwd;

   function automatic logic addr_ok(input logic [AW-1:0] a);
      return ({1'b0, a} < (AW+1)'(NUM_REGS)) && !(ZERO_REG != 0 && a == AW'(ZERO_ADDR));
   endfunction

   for (genvar p = 0; p < NUM_WR; p++) begin : g_wr
      assign wa[p]    = wr_addr[p*AW +: AW];
      assign wd[p]    = wr_data[p*DW +: DW];
      assign wr_ok[p] = wr_en[p] && addr_ok(wa[p]);
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      assign ra[k] = rd_addr[k*AW +: AW];
   end

   for (genvar r = 0; r < NUM_REGS; r++) begin : g_view
      assign register_file[r*DW +: DW] = regs[r];
   end

   // Ascending port order makes the highest-index port win on an address clash.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NUM_REGS; r++)
            regs[r] <= '0;
      end else begin
         for (int p = 0; p < NUM_WR; p++)
            if (wr_ok[p])
               regs[wa[p]] <= wd[p];
      end
   end

   always_comb begin
      rd_data = '0;
      fwd     = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         if (addr_ok(ra[k]))
            rd_data[k*DW +: DW] = regs[ra[k]];
         if (BYPASS != 0) begin
            for (int p = 0; p < NUM_WR; p++) begin
               if (wr_ok[p] && wa[p] == ra[k]) begin
                  rd_data[k*DW +: DW] = wd[p];
                  fwd[k]              = 1'b1;
               end
            end
         end
      end
   end

   regfile_scoreboard #(
      .ADDRESS_WIDTH (ADDRESS_WIDTH),
      .NUM_REGS      (NUM_REGS),
      .NUM_RD        (NUM_RD),
      .NUM_WR        (NUM_WR),
      .ZERO_REG      (ZERO_REG)
   ) u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .wr_ok    (wr_ok),
      .wr_addr  (wr_addr),
      .rd_addr  (rd_addr),
      .fwd      (fwd),
      .rd_busy  (rd_busy)
   );
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a bypassing 32-entry instance and a non-bypassing 24-entry instance
// share one stimulus stream and are checked against an array-based reference model.
module tb_regfile_mp;
   import regfile_pkg::*;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [1:0]    wr_en;
   logic [9:0]    wr_addr;
   logic [63:0]   wr_data;
   logic [9:0]    rd_addr;
   logic          rsv_en;
   logic [4:0]    rsv_addr;
   logic          flush;
   logic [63:0]   rd_data_b, rd_data_n;
   logic [1:0]    rd_busy_b, rd_busy_n;
   logic [32*32-1:0] rf_b;
   logic [24*32-1:0] rf_n;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q[$];

   // model state: index 0 = bypassing 32-entry file, index 1 = non-bypassing 24-entry file
   reg_data_t m_mem  [2][32];
   bit        m_busy [2][32];

   regfile_mp #(.NUM_REGS(32), .BYPASS(1)) dut_b (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush), .register_file(rf_b));

   regfile_mp #(.NUM_REGS(24), .BYPASS(0)) dut_n (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush), .register_file(rf_n));

   // clock / reset
   always #5 clk = ~clk;

   function automatic int nregs(input int d);
      return (d == 0) ? 32 : 24;
   endfunction

   function automatic int w_a(input int p);
      return int'(wr_addr[p*5 +: 5]);
   endfunction

   // reference model: a write is visible only when enabled, nonzero and in range
   function automatic bit w_valid(input int d, input int p);
      return wr_en[p] && w_a(p) != 0 && w_a(p) < nregs(d);
   endfunction

   function automatic logic [31:0] m_rd(input int d, input int a);
      logic [31:0] v;
      if (a == 0 || a >= nregs(d)) return 32'h0;
      v = m_mem[d][a];
      if (d == 0)
         for (int p = 0; p < 2; p++)
            if (w_valid(d, p) && w_a(p) == a) v = wr_data[p*32 +: 32];
      return v;
   endfunction

   function automatic logic m_bz(input int d, input int a);
      if (a == 0 || a >= nregs(d)) return 1'b0;
      if (d == 0)
         for (int p = 0; p < 2; p++)
            if (w_valid(d, p) && w_a(p) == a) return 1'b0;
      return m_busy[d][a];
   endfunction

   task automatic m_clear();
      for (int d = 0; d < 2; d++)
         for (int r = 0; r < 32; r++) begin
            m_mem[d][r]  = '0;
            m_busy[d][r] = 1'b0;
         end
   endtask

   task automatic m_edge();
      bit hit;
      if (rst) begin
         m_clear();
         return;
      end
      for (int d = 0; d < 2; d++) begin
         for (int r = 1; r < nregs(d); r++) begin
            hit = 1'b0;
            for (int p = 0; p < 2; p++)
               if (w_valid(d, p) && w_a(p) == r) hit = 1'b1;
            if (flush)                                m_busy[d][r] = 1'b0;
            else if (rsv_en && int'(rsv_addr) == r)   m_busy[d][r] = 1'b1;
            else if (hit)                             m_busy[d][r] = 1'b0;
         end
         for (int p = 0; p < 2; p++)
            if (w_valid(d, p)) m_mem[d][w_a(p)] = wr_data[p*32 +: 32];
      end
   endtask

   // scoreboard
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      logic [31:0] e;
      total++;
      exp_q.push_back(exp);
      e = exp_q.pop_front();
      assert (got === e) else begin
         bad++;
         $error("FAIL %s: got=%h exp=%h", tag, got, e);
      end
   endtask

   task automatic check_all(input string tag);
      int a;
      for (int k = 0; k < 2; k++) begin
         a = int'(rd_addr[k*5 +: 5]);
         chk($sformatf("%s b rd%0d a%0d", tag, k, a), rd_data_b[k*32 +: 32], m_rd(0, a));
         chk($sformatf("%s n rd%0d a%0d", tag, k, a), rd_data_n[k*32 +: 32], m_rd(1, a));
         chk($sformatf("%s b busy%0d a%0d", tag, k, a), {31'b0, rd_busy_b[k]}, {31'b0, m_bz(0, a)});
         chk($sformatf("%s n busy%0d a%0d", tag, k, a), {31'b0, rd_busy_n[k]}, {31'b0, m_bz(1, a)});
      end
      for (int r = 0; r < 32; r++)
         chk($sformatf("%s b rf%0d", tag, r), rf_b[r*32 +: 32], m_mem[0][r]);
      for (int r = 0; r < 24; r++)
         chk($sformatf("%s n rf%0d", tag, r), rf_n[r*32 +: 32], m_mem[1][r]);
   endtask

   // drivers: inputs change just after a falling edge, outputs sampled 1 ns later
   task automatic step(input string tag);
      #1 check_all(tag);
      @(posedge clk);
      m_edge();
      @(negedge clk);
   endtask

   task automatic idle();
      wr_en  = '0;
      rsv_en = 1'b0;
      flush  = 1'b0;
   endtask

   task automatic wr(input int p, input logic [4:0] a, input logic [31:0] dat);
      wr_en[p]           = 1'b1;
      wr_addr[p*5 +: 5]  = a;
      wr_data[p*32 +: 32] = dat;
   endtask

   task automatic rd(input int k, input logic [4:0] a);
      rd_addr[k*5 +: 5] = a;
   endtask

   task automatic rsv(input logic [4:0] a);
      rsv_en   = 1'b1;
      rsv_addr = a;
   endtask

   initial begin
      idle();
      wr_addr  = '0;
      wr_data  = '0;
      rd_addr  = '0;
      rsv_addr = '0;
      m_clear();
      @(negedge clk);
      check_all("reset");
      rst = 1'b0;
      step("post_reset");

      // asynchronous reset between edges wipes a stored value immediately
      wr(0, 5'd5, 32'hDEADBEEF); rd(0, 5'd5); rsv(5'd5);
      step("w_r5");
      idle();
      #1 chk("r5_stored", rd_data_b[31:0], 32'hDEADBEEF);
      rst = 1'b1;
      m_clear();
      #1 chk("rst_r5_b", rd_data_b[31:0], 32'h0);
      chk("rst_r5_n", rd_data_n[31:0], 32'h0);
      chk("rst_busy_b", {30'b0, rd_busy_b}, 32'h0);
      chk("rst_busy_n", {30'b0, rd_busy_n}, 32'h0);
      @(posedge clk); m_edge();
      @(negedge clk); rst = 1'b0;

      // dual write to the same address: port 1 wins
      wr(0, 5'd7, 32'h11); wr(1, 5'd7, 32'h22); rd(0, 5'd7);
      #1 chk("dual_byp", rd_data_b[31:0], 32'h22);
      chk("dual_nobyp", rd_data_n[31:0], 32'h0);
      step("dual");
      idle();
      #1 chk("dual_b", rd_data_b[31:0], 32'h22);
      chk("dual_n", rd_data_n[31:0], 32'h22);

      // x0 ignores writes and reservations
      wr(0, 5'd0, 32'h5A5A); rsv(5'd0); rd(0, 5'd0); rd(1, 5'd0);
      #1 chk("x0_byp", rd_data_b[31:0], 32'h0);
      chk("x0_busy_now", {30'b0, rd_busy_b}, 32'h0);
      step("x0");
      idle();
      #1 chk("x0_b", rd_data_b[31:0], 32'h0);
      chk("x0_n", rd_data_n[31:0], 32'h0);
      chk("x0_busy_b", {30'b0, rd_busy_b}, 32'h0);
      chk("x0_busy_n", {30'b0, rd_busy_n}, 32'h0);

      // reserve r3, then writeback at cycle 4 clears busy with bypassed data
      rsv(5'd3); rd(0, 5'd3); rd(1, 5'd3);
      step("rsv3");
      idle();
      for (int i = 1; i < 4; i++) begin
         #1 chk($sformatf("r3_busy_c%0d", i), {31'b0, rd_busy_b[0]}, 32'h1);
         step("r3_wait");
      end
      wr(0, 5'd3, 32'h40);
      #1 chk("r3_wb_busy_b", {31'b0, rd_busy_b[0]}, 32'h0);
      chk("r3_wb_data_b", rd_data_b[31:0], 32'h40);
      chk("r3_wb_busy_n", {31'b0, rd_busy_n[0]}, 32'h1);
      chk("r3_wb_data_n", rd_data_n[31:0], 32'h0);
      step("r3_wb");
      idle();
      #1 chk("r3_after_b", rd_data_b[31:0], 32'h40);
      chk("r3_after_n", rd_data_n[31:0], 32'h40);
      chk("r3_after_busy_n", {31'b0, rd_busy_n[0]}, 32'h0);

      // reservation and write to the same register in one cycle: reservation wins
      rsv(5'd9); wr(0, 5'd9, 32'h9); rd(0, 5'd9);
      step("rsv_wr9");
      idle();
      #1 chk("r9_data", rd_data_b[31:0], 32'h9);
      chk("r9_busy_b", {31'b0, rd_busy_b[0]}, 32'h1);
      chk("r9_busy_n", {31'b0, rd_busy_n[0]}, 32'h1);

      // flush clears all busy bits and suppresses a same-cycle reservation
      rsv(5'd1); step("rsv1");
      rsv(5'd2); step("rsv2");
      rsv(5'd4); step("rsv4");
      flush = 1'b1; rsv(5'd6); rd(0, 5'd1); rd(1, 5'd6);
      step("flush");
      idle();
      #1 chk("flush_b", {30'b0, rd_busy_b}, 32'h0);
      chk("flush_n", {30'b0, rd_busy_n}, 32'h0);
      rd(0, 5'd2); rd(1, 5'd4);
      #1 chk("flush_24", {30'b0, rd_busy_b}, 32'h0);

      // without bypass new data appears one cycle later
      wr(0, 5'd8, 32'h77); rd(0, 5'd8);
      #1 chk("r8_now_n", rd_data_n[31:0], 32'h0);
      chk("r8_now_b", rd_data_b[31:0], 32'h77);
      step("r8");
      idle();
      #1 chk("r8_next_n", rd_data_n[31:0], 32'h77);

      // address beyond the 24-entry file is dropped there and reads 0
      wr(1, 5'd30, 32'hABCD); rsv(5'd30); rd(0, 5'd30);
      step("oor");
      idle();
      #1 chk("oor_n", rd_data_n[31:0], 32'h0);
      chk("oor_busy_n", {31'b0, rd_busy_n[0]}, 32'h0);
      chk("oor_b", rd_data_b[31:0], 32'hABCD);
      chk("oor_busy_b", {31'b0, rd_busy_b[0]}, 32'h1);

      // randomized traffic, narrow address range half the time to force collisions
      for (int i = 0; i < 400; i++) begin
         idle();
         for (int p = 0; p < 2; p++)
            if ($urandom_range(0, 1) == 1)
               wr(p, 5'($urandom_range(0, (i % 2 == 0) ? 11 : 31)), $urandom);
         for (int k = 0; k < 2; k++)
            rd(k, 5'($urandom_range(0, (i % 2 == 0) ? 11 : 31)));
         if ($urandom_range(0, 2) == 0) rd(0, wr_addr[4:0]);
         if ($urandom_range(0, 1) == 1) rsv(5'($urandom_range(0, (i % 2 == 0) ? 11 : 31)));
         flush = ($urandom_range(0, 15) == 0);
         step("rand");
      end

      idle();
      step("final");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file, successor of the single-write/dual-read pipeline register file. Provides NUM_RD combinational read ports, NUM_WR prioritised write ports, optional hardwired-zero x0, write-to-read bypass, and a per-register busy scoreboard for decode-stage hazard detection. Sits between decode (reads, reservations) and writeback (writes, busy clear).

Parameters:
DATA_WIDTH, 32, bits per register
ADDRESS_WIDTH, 5, register address bits
NUM_REGS, 32, register count (<= 2**ADDRESS_WIDTH)
NUM_RD, 2, read ports (1..4)
NUM_WR, 2, write ports (1..2)
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and reservations
BYPASS, 1, 1 = same-cycle write data forwarded to read ports

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
wr_en  in  NUM_WR  per-port write enable
wr_addr  in  NUM_WR*ADDRESS_WIDTH  packed write addresses, port p at [p*AW +: AW]
wr_data  in  NUM_WR*DATA_WIDTH  packed write data
rd_addr  in  NUM_RD*ADDRESS_WIDTH  packed read addresses
rd_data  out  NUM_RD*DATA_WIDTH  packed read data
rd_busy  out  NUM_RD  scoreboard busy for each read address
rsv_en  in  1  reserve (mark busy) destination at decode
rsv_addr  in  ADDRESS_WIDTH  register to reserve
flush  in  1  synchronous clear of entire scoreboard
register_file  out  NUM_REGS*DATA_WIDTH  packed debug view of all registers

Behaviour:
- Reset (rst=1, asynchronous): all registers 0, all busy bits 0; rd_data/rd_busy follow combinationally (0 unless bypassed write active). Reset mid-write: write lost.
- Write: on rising clk, for each p with wr_en[p]=1 and wr_addr < NUM_REGS, reg[wr_addr] <= wr_data. Same address on multiple ports: highest port index wins. Address >= NUM_REGS: ignored.
- ZERO_REG=1: writes to address 0 dropped; reads of 0 return 0, busy 0, never bypassed.
- Read: combinational, zero latency. Address >= NUM_REGS returns 0, busy 0.
- BYPASS=1: if any enabled write targets the read address this cycle, rd_data = that write's data (highest port wins); else stored value. BYPASS=0: stored value only (new data visible next cycle).
- Scoreboard: one busy bit per register, next state per rising edge:
  - flush=1: all bits cleared; rsv_en same cycle ignored.
  - else bit set if rsv_en and rsv_addr matches; else cleared if any enabled write matches; else hold.
  - reserve and write to same address same cycle: reserve wins (newer producer), bit = 1.
- rd_busy[k] = busy[rd_addr[k]], except forced 0 when BYPASS=1 and an enabled write to that address is present this cycle (data already forwarded).
- Reservation of already-busy register: stays 1 (no counting; single outstanding producer per register).
- No file I/O in synthesizable path; write logging only under a simulation-only guard.

Decomposition:
- Package regfile_pkg: default width/depth localparams, reg_addr_t / reg_data_t typedefs, ZERO_ADDR constant.
- Sub-module regfile_scoreboard: busy vector, rsv/write-clear/flush logic, busy lookup per read port. Storage array, write priority and bypass muxing stay in regfile_mp.

Test Plan:
- Reset: write 0xDEADBEEF to r5, assert rst between edges -> r5 reads 0x0 immediately, all rd_busy 0.
- Dual write conflict: wr_en=2'b11, both addr 7, data 0x11/0x22 -> after edge r7 = 0x22; with BYPASS=1 rd_data for addr 7 = 0x22 in the same cycle.
- x0: write 0x5A5A to r0 and rsv_addr=0 -> reads 0x0, rd_busy 0 forever.
- Scoreboard: rsv r3 at cycle 0 -> rd_busy=1 from cycle 1; write r3=0x40 at cycle 4 -> rd_busy 0 and rd_data 0x40 in cycle 4 (bypass), stored from cycle 5.
- Reserve-vs-write collision: rsv r9 and write r9=0x9 same cycle -> r9 = 0x9, busy stays 1.
- Flush: busy r1,r2,r4 set, flush=1 with rsv r6 -> all busy 0 next cycle, r6 not busy; BYPASS=0 build: write r8=0x77 -> read 0 same cycle, 0x77 next.
